// File: rtl/stack_mem_mover_pkg.sv
// Shared opcodes, FSM state encoding and the command guard used by the
// stack/memory mover.
package stack_mem_mover_pkg;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_PUSHI = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_RDW  = 3'd2,
      S_POP  = 3'd3,
      S_POPW = 3'd4,
      S_WR   = 3'd5,
      S_PSH  = 3'd6,
      S_ERR  = 3'd7
   } state_t;

   // A command is refused if it would overflow or underflow the stack, or is reserved.
   function automatic logic cmd_refused(input logic [1:0] op,
                                        input logic       full,
                                        input logic       empty);
      case (op)
         OP_LOAD:  return full;
         OP_STORE: return empty;
         OP_PUSHI: return full;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/stack_mem_mover_depth_counter.sv
// Stack occupancy counter: saturates at both ends so it can never wrap.
module stack_mem_mover_depth_counter #(
   parameter int DEPTH   = 32,
   parameter int DEPTH_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               dec,
   output logic [DEPTH_W-1:0] count,
   output logic               full,
   output logic               empty
);

   assign full  = (count == DEPTH_W'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + DEPTH_W'(1);
      end else if (dec && !inc && !empty) begin
         count <= count - DEPTH_W'(1);
      end
   end

endmodule

// File: rtl/stack_mem_mover.sv
// Executes LOAD / STORE / PUSHI commands between the data memory and the
// operand stack, one at a time, refusing commands that break stack bounds.
module stack_mem_mover
   import stack_mem_mover_pkg::*;
#(
   parameter int AW      = 5,
   parameter int DW      = 8,
   parameter int DEPTH   = 32,
   parameter int DEPTH_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   // cmd: accepted on a rising edge where cmd_valid && cmd_ready; cmd_ready is
   // high only in IDLE and op/addr/imm are captured on that edge.
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [AW-1:0]      cmd_addr,
   input  logic [DW-1:0]      cmd_imm,
   output logic               done,
   output logic               err,
   output logic [DEPTH_W-1:0] depth,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   output logic               mem_read,
   output logic               mem_write,
   input  logic [DW-1:0]      mem_rdata,
   output logic [DW-1:0]      stk_din,
   output logic               stk_push,
   output logic               stk_pop,
   input  logic [DW-1:0]      stk_dout,
   output state_t             dbg_state,
   output logic [1:0]         dbg_op,
   output logic [DW-1:0]      dbg_data
);

   state_t          state_q, state_d;
   logic [1:0]      op_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;
   logic            full, empty;
   logic            accept;

   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_refused(cmd_op, full, empty)) state_d = S_ERR;
               else if (cmd_op == OP_LOAD)           state_d = S_RD;
               else if (cmd_op == OP_STORE)          state_d = S_POP;
               else                                  state_d = S_PSH;
            end
         end
         S_RD:    state_d = S_RDW;
         S_RDW:   state_d = S_PSH;
         S_POP:   state_d = S_POPW;
         S_POPW:  state_d = S_WR;
         S_WR:    state_d = S_IDLE;
         S_PSH:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode the current state only, so an async reset drops them at once.
   assign cmd_ready = (state_q == S_IDLE);
   assign mem_read  = (state_q == S_RD);
   assign mem_write = (state_q == S_WR);
   assign stk_pop   = (state_q == S_POP);
   assign stk_push  = (state_q == S_PSH);
   assign err       = (state_q == S_ERR);
   assign done      = (state_q == S_PSH) || (state_q == S_WR) || (state_q == S_ERR);

   // Address/data outputs are loaded on entry to their strobe state and then held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q      <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         stk_din   <= '0;
      end else begin
         if (accept) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
            if (state_d == S_RD)  mem_addr <= cmd_addr;
            if (state_d == S_PSH) stk_din  <= cmd_imm;
         end
         if (state_q == S_RDW) begin
            data_q  <= mem_rdata;
            stk_din <= mem_rdata;
         end
         if (state_q == S_POPW) begin
            data_q    <= stk_dout;
            mem_addr  <= addr_q;
            mem_wdata <= stk_dout;
         end
      end
   end

   stack_mem_mover_depth_counter #(
      .DEPTH   (DEPTH),
      .DEPTH_W (DEPTH_W)
   ) u_depth (
      .clk   (clk),
      .rst   (rst),
      .inc   (stk_push),
      .dec   (stk_pop),
      .count (depth),
      .full  (full),
      .empty (empty)
   );

   assign dbg_state = state_q;
   assign dbg_op    = op_q;
   assign dbg_data  = data_q;

endmodule

// File: tb/tb_stack_mem_mover.sv
// Directed bench for stack_mem_mover with behavioural memory and stack models.
module tb_stack_mem_mover;
   import stack_mem_mover_pkg::*;

   localparam int AW = 5, DW = 8, DEPTH = 32, DEPTH_W = 6;

   logic               clk, rst;
   logic               cmd_valid, cmd_ready;
   logic [1:0]         cmd_op;
   logic [AW-1:0]      cmd_addr;
   logic [DW-1:0]      cmd_imm;
   logic               done, err;
   logic [DEPTH_W-1:0] depth;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata, mem_rdata;
   logic               mem_read, mem_write;
   logic [DW-1:0]      stk_din, stk_dout;
   logic               stk_push, stk_pop;
   state_t             dbg_state;
   logic [1:0]         dbg_op;
   logic [DW-1:0]      dbg_data;

   stack_mem_mover #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_imm   (cmd_imm),
      .done      (done),
      .err       (err),
      .depth     (depth),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .stk_din   (stk_din),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_dout  (stk_dout),
      .dbg_state (dbg_state),
      .dbg_op    (dbg_op),
      .dbg_data  (dbg_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model with a backdoor write port for preloading
   logic [DW-1:0] mem [32];
   logic          bk_we;
   logic [AW-1:0] bk_addr;
   logic [DW-1:0] bk_data;

   always @(posedge clk) begin
      if (bk_we)     mem[bk_addr]  <= bk_data;
      if (mem_read)  mem_rdata     <= mem[mem_addr];
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   // stack model
   logic [DW-1:0] stk [32];
   int            sp;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp <= 0;
      end else begin
         if (stk_push && sp < 32) begin
            stk[sp] <= stk_din;
            sp      <= sp + 1;
         end
         if (stk_pop && sp > 0) begin
            stk_dout <= stk[sp-1];
            sp       <= sp - 1;
         end
      end
   end

   // scoreboard
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // per-command observations, cycle numbers counted from the accept edge
   int            rd_cyc, push_cyc, pop_cyc, wr_cyc, done_cyc, strobes, excl_viol, ready_busy;
   logic          err_seen;
   logic [DW-1:0] push_data, wr_data;
   logic [AW-1:0] rd_addr, wr_addr;

   task automatic clear_obs();
      rd_cyc = 0; push_cyc = 0; pop_cyc = 0; wr_cyc = 0; done_cyc = 0;
      strobes = 0; excl_viol = 0; ready_busy = 0; err_seen = 1'b0;
      push_data = '0; wr_data = '0; rd_addr = '0; wr_addr = '0;
   endtask

   task automatic sample(input int c);
      if (mem_read)  begin strobes++; rd_cyc = c; rd_addr = mem_addr; end
      if (stk_push)  begin strobes++; push_cyc = c; push_data = stk_din; end
      if (stk_pop)   begin strobes++; pop_cyc = c; end
      if (mem_write) begin strobes++; wr_cyc = c; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (done)      done_cyc = c;
      if (err)       err_seen = 1'b1;
      if ((mem_read && mem_write) || (stk_push && stk_pop)) excl_viol++;
      if (cmd_ready) ready_busy++;
   endtask

   // driver: one command, observe until done (bounded), then one more cycle
   task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] imm);
      clear_obs();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_imm = imm;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         sample(c);
         if (done) break;
         @(negedge clk);
      end
      if (done_cyc == 0) check("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic check_refused(input string tag, input logic [DEPTH_W-1:0] exp_depth);
      check({tag, "_err"},     {31'd0, err_seen}, 32'd1);
      check({tag, "_done"},    done_cyc, 32'd1);
      check({tag, "_strobes"}, strobes, 32'd0);
      check({tag, "_depth"},   {26'd0, depth}, {26'd0, exp_depth});
   endtask

   logic ready_at4;

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_imm = '0;
      bk_we = 1'b1; bk_addr = 5'd3; bk_data = 8'h3C;
      repeat (2) @(posedge clk);
      #1;
      check("rst_strobes", {26'd0, mem_read, mem_write, stk_push, stk_pop, done, err}, 32'd0);
      check("rst_depth", {26'd0, depth}, 32'd0);
      @(negedge clk);
      bk_we = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_outs", {8'd0, 3'd0, mem_addr, mem_wdata, stk_din}, 32'd0);

      // PUSHI A5
      issue(OP_PUSHI, 5'd0, 8'hA5);
      check("pushi_push_cyc", push_cyc, 32'd1);
      check("pushi_data", {24'd0, push_data}, 32'hA5);
      check("pushi_depth", {26'd0, depth}, 32'd1);

      // LOAD mem[3]=3C
      issue(OP_LOAD, 5'd3, 8'h00);
      check("load_rd_cyc", rd_cyc, 32'd1);
      check("load_rd_addr", {27'd0, rd_addr}, 32'd3);
      check("load_push_cyc", push_cyc, 32'd3);
      check("load_done_cyc", done_cyc, 32'd3);
      check("load_data", {24'd0, push_data}, 32'h3C);
      check("load_depth", {26'd0, depth}, 32'd2);

      // STORE top 5A to addr 7
      issue(OP_PUSHI, 5'd0, 8'h5A);
      issue(OP_STORE, 5'd7, 8'h00);
      check("store_pop_cyc", pop_cyc, 32'd1);
      check("store_wr_cyc", wr_cyc, 32'd3);
      check("store_wr_addr", {27'd0, wr_addr}, 32'd7);
      check("store_mem7", {24'd0, mem[7]}, 32'h5A);
      check("store_depth", {26'd0, depth}, 32'd2);
      check("store_excl", excl_viol, 32'd0);

      // drain: LIFO order
      issue(OP_STORE, 5'd8, 8'h00);
      issue(OP_STORE, 5'd9, 8'h00);
      check("lifo_mem8", {24'd0, mem[8]}, 32'h3C);
      check("lifo_mem9", {24'd0, mem[9]}, 32'hA5);
      check("drain_depth", {26'd0, depth}, 32'd0);

      // refused: underflow and reserved opcode
      issue(OP_STORE, 5'd11, 8'h00);
      check_refused("store_empty", 6'd0);
      issue(2'b11, 5'd0, 8'h00);
      check_refused("op_reserved", 6'd0);

      // fill to capacity, then overflow attempts
      for (int i = 0; i < DEPTH; i++) issue(OP_PUSHI, 5'd0, 8'(i));
      check("fill_depth", {26'd0, depth}, 32'd32);
      issue(OP_PUSHI, 5'd0, 8'hEE);
      check_refused("pushi_full", 6'd32);
      issue(OP_LOAD, 5'd3, 8'h00);
      check_refused("load_full", 6'd32);
      issue(OP_STORE, 5'd10, 8'h00);
      check("full_top_mem10", {24'd0, mem[10]}, 32'h1F);
      check("full_pop_depth", {26'd0, depth}, 32'd31);

      // back-to-back with cmd_valid held: LOAD 3 then STORE 12
      clear_obs();
      ready_at4 = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_addr = 5'd3;
      for (int t = 1; t <= 7; t++) begin
         @(negedge clk);
         if (t == 5) cmd_valid = 1'b0;
         if (t == 4) ready_at4 = cmd_ready;
         sample(t);
         if (t == 3 && done) begin cmd_op = OP_STORE; cmd_addr = 5'd12; end
      end
      @(negedge clk);
      check("b2b_ready_idle", {31'd0, ready_at4}, 32'd1);
      check("b2b_ready_total", ready_busy, 32'd1);
      check("b2b_push_cyc", push_cyc, 32'd3);
      check("b2b_pop_cyc", pop_cyc, 32'd5);
      check("b2b_wr_cyc", wr_cyc, 32'd7);
      check("b2b_mem12", {24'd0, mem[12]}, 32'h3C);
      check("b2b_depth", {26'd0, depth}, 32'd31);

      // reset during RDW of a LOAD
      clear_obs();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_addr = 5'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("mid_rd", {31'd0, mem_read}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_strobes", {26'd0, mem_read, mem_write, stk_push, stk_pop, done, err}, 32'd0);
      check("mid_depth", {26'd0, depth}, 32'd0);
      for (int t = 0; t < 3; t++) begin @(negedge clk); sample(t); end
      rst = 1'b1;
      for (int t = 0; t < 3; t++) begin @(negedge clk); sample(t); end
      check("mid_no_strobe", strobes, 32'd0);
      check("mid_ready", {31'd0, cmd_ready}, 32'd1);
      check("mid_depth_after", {26'd0, depth}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
